// File: rtl/riscv_pkg.sv
// Shared core constants and the decode-to-execute operand bundle.
// Used by the register file, scoreboard and operand fetch.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
  } s1_t;

  // Writeback hits register r this edge (x0 is never written).
  function automatic logic wb_hit(
    input logic              en,
    input logic [REG_AW-1:0] wrd,
    input logic [REG_AW-1:0] r
  );
    return en && (wrd == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports: CLK/RST, set (accept rd), clr (writeback rd), 3 busy queries.
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] qa_rs,
  output logic              qa_busy,
  input  logic [REG_AW-1:0] qb_rs,
  output logic              qb_busy,
  input  logic [REG_AW-1:0] qd_rs,
  output logic              qd_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clear first so a same-edge set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_rd] = 1'b0;
    if (set_en) busy_d[set_rd] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign qa_busy = busy_q[qa_rs];
  assign qb_busy = busy_q[qb_rs];
  assign qd_busy = busy_q[qd_rs];

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch: regfile read addressing, writeback bypass, RAW/WAW stall.
// Ports: decode in_* (valid/ready), rf_* read port, wb_* snoop, execute out_*.
module operand_fetch_unit
  import riscv_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  output logic [REG_AW-1:0] rf_add_a,
  output logic [REG_AW-1:0] rf_add_b,
  input  logic [XLEN-1:0]   rf_info_a,
  input  logic [XLEN-1:0]   rf_info_b,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op_a,
  output logic [XLEN-1:0]   out_op_b,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we
);

  s1_t             s1_q;
  logic            s1_valid_q;
  logic [XLEN-1:0] byp_a_q;
  logic [XLEN-1:0] byp_b_q;
  logic            flag_a_q;
  logic            flag_b_q;

  logic wb_act;
  logic busy_a;
  logic busy_b;
  logic busy_d;
  logic hazard;
  logic hold;
  logic accept;
  logic set_en;
  logic hit_in_a;
  logic hit_in_b;
  logic hit_in_d;
  logic hit_s1_a;
  logic hit_s1_b;

  assign wb_act = wb_en & ~RST;

  assign hit_in_a = wb_hit(wb_act, wb_rd, in_rs1);
  assign hit_in_b = wb_hit(wb_act, wb_rd, in_rs2);
  assign hit_in_d = wb_hit(wb_act, wb_rd, in_rd);
  assign hit_s1_a = wb_hit(wb_act, wb_rd, s1_q.rs1);
  assign hit_s1_b = wb_hit(wb_act, wb_rd, s1_q.rs2);

  reg_scoreboard u_sb (
    .CLK     (CLK),
    .RST     (RST),
    .set_en  (set_en),
    .set_rd  (in_rd),
    .clr_en  (wb_act),
    .clr_rd  (wb_rd),
    .qa_rs   (in_rs1),
    .qa_busy (busy_a),
    .qb_rs   (in_rs2),
    .qb_busy (busy_b),
    .qd_rs   (in_rd),
    .qd_busy (busy_d)
  );

  // A writeback landing this edge resolves the hazard it would cause.
  assign hazard = (busy_a & ~hit_in_a)
                | (busy_b & ~hit_in_b)
                | (in_rd_we & (in_rd != REG_ZERO)
                   & busy_d & ~hit_in_d);

  assign hold     = s1_valid_q & ~out_ready;
  assign in_ready = ~hold & ~hazard;
  assign accept   = in_valid & in_ready;
  assign set_en   = accept & in_rd_we & (in_rd != REG_ZERO);

  // A held instruction keeps re-reading so its operands stay current.
  assign rf_add_a = hold ? s1_q.rs1 : in_rs1;
  assign rf_add_b = hold ? s1_q.rs2 : in_rs2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      byp_a_q    <= '0;
      byp_b_q    <= '0;
      flag_a_q   <= 1'b0;
      flag_b_q   <= 1'b0;
    end else if (accept) begin
      s1_q       <= '{in_rs1, in_rs2, in_rd, in_rd_we};
      s1_valid_q <= 1'b1;
      flag_a_q   <= hit_in_a;
      flag_b_q   <= hit_in_b;
      if (hit_in_a) byp_a_q <= wb_data;
      if (hit_in_b) byp_b_q <= wb_data;
    end else if (hold) begin
      // Regfile read on this edge returns the pre-write value.
      if (hit_s1_a) begin
        byp_a_q  <= wb_data;
        flag_a_q <= 1'b1;
      end
      if (hit_s1_b) begin
        byp_b_q  <= wb_data;
        flag_b_q <= 1'b1;
      end
    end else begin
      s1_valid_q <= 1'b0;
    end
  end

  always_comb begin
    out_valid = s1_valid_q;
    out_op_a  = '0;
    out_op_b  = '0;
    out_rd    = '0;
    out_rd_we = 1'b0;
    if (s1_valid_q) begin
      out_rd    = s1_q.rd;
      out_rd_we = s1_q.rd_we;
      if (s1_q.rs1 != REG_ZERO)
        out_op_a = flag_a_q ? byp_a_q : rf_info_a;
      if (s1_q.rs2 != REG_ZERO)
        out_op_b = flag_b_q ? byp_b_q : rf_info_b;
    end
  end

endmodule
